// File: rtl/serial_tsi_pkg.sv
// serial_tsi_pkg: sequencer states and link word constants shared by the serial TSI master.
package serial_tsi_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA, S_RDWAIT, S_RESP
  } state_e;
  localparam logic [31:0] CMD_READ   = 32'd0;
  localparam logic [31:0] CMD_WRITE  = 32'd1;
  localparam logic [31:0] LEN_SINGLE = 32'd0;
endpackage

// File: rtl/serial_tsi_timeout.sv
// serial_tsi_timeout: read-wait cycle counter; expired_o flags the last allowed wait cycle.
module serial_tsi_timeout #(
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int TO_W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  assign expired_o = cnt_q == TO_W'(TIMEOUT_CYCLES - 1);
  assign cnt_d = clr_i ? '0 : (en_i && !expired_o) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/serial_tsi_master.sv
// serial_tsi_master: serialises single-word host read/write requests onto the TSI word stream
// and collects the read reply, reporting an error if the target stays silent too long.
module serial_tsi_master
  import serial_tsi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int TO_W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        serial_in_valid,
  input  logic        serial_in_ready,
  output logic [31:0] serial_in_bits,
  input  logic        serial_out_valid,
  output logic        serial_out_ready,
  input  logic [31:0] serial_out_bits,
  output logic        busy
);
  state_e      state_q, state_d;
  logic        live_q, write_q, err_q, expired;
  logic [63:0] addr_q;
  logic [31:0] wdata_q, rdata_q;
  serial_tsi_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i    (clock),
    .rst_ni   (reset),
    .clr_i    (state_q != S_RDWAIT),
    .en_i     (state_q == S_RDWAIT),
    .expired_o(expired)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = (req_valid && req_ready) ? S_CMD : S_IDLE;
      S_CMD:     state_d = serial_in_ready ? S_ADDR_LO : S_CMD;
      S_ADDR_LO: state_d = serial_in_ready ? S_ADDR_HI : S_ADDR_LO;
      S_ADDR_HI: state_d = serial_in_ready ? S_LEN_LO : S_ADDR_HI;
      S_LEN_LO:  state_d = serial_in_ready ? S_LEN_HI : S_LEN_LO;
      S_LEN_HI:  state_d = !serial_in_ready ? S_LEN_HI : write_q ? S_DATA : S_RDWAIT;
      S_DATA:    state_d = serial_in_ready ? S_RESP : S_DATA;
      S_RDWAIT:  state_d = (serial_out_valid || expired) ? S_RESP : S_RDWAIT;
      S_RESP:    state_d = resp_ready ? S_IDLE : S_RESP;
      default:   state_d = S_IDLE;
    endcase
  end
  always_comb begin
    req_ready        = live_q && state_q == S_IDLE;
    serial_in_valid  = state_q inside {S_CMD, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA};
    serial_out_ready = state_q == S_RDWAIT;
    resp_valid       = state_q == S_RESP;
    busy             = state_q != S_IDLE;
    serial_in_bits   = '0;
    case (state_q)
      S_CMD:              serial_in_bits = write_q ? CMD_WRITE : CMD_READ;
      S_ADDR_LO:          serial_in_bits = addr_q[31:0];
      S_ADDR_HI:          serial_in_bits = addr_q[63:32];
      S_LEN_LO, S_LEN_HI: serial_in_bits = LEN_SINGLE;
      S_DATA:             serial_in_bits = wdata_q;
      default:            serial_in_bits = '0;
    endcase
  end
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  // Reply data takes priority over expiry when both land in the same wait cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      live_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (req_valid && req_ready) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == S_DATA && serial_in_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if (state_q == S_RDWAIT && serial_out_valid) begin
        rdata_q <= serial_out_bits;
        err_q   <= 1'b0;
      end else if (state_q == S_RDWAIT && expired) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_tsi_master.sv
// tb_serial_tsi_master: directed scenarios for the serial TSI master with an 8-cycle timeout.
module tb_serial_tsi_master;
  logic        clock = 1'b0, reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;
  logic        serial_in_valid, serial_in_ready = 1'b0;
  logic [31:0] serial_in_bits;
  logic        serial_out_valid = 1'b0, serial_out_ready;
  logic [31:0] serial_out_bits = '0;
  logic        busy;
  int          n_cmp = 0, n_bad = 0;

  serial_tsi_master #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .serial_in_valid(serial_in_valid), .serial_in_ready(serial_in_ready), .serial_in_bits(serial_in_bits),
    .serial_out_valid(serial_out_valid), .serial_out_ready(serial_out_ready), .serial_out_bits(serial_out_bits),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Issues one request with serial_in_ready high and checks every link word; returns one cycle after the last word.
  task automatic issue(input logic wr, input logic [63:0] addr, input logic [31:0] wd);
    logic [31:0] exp [6];
    exp[0] = wr ? 32'd1 : 32'd0;
    exp[1] = addr[31:0];
    exp[2] = addr[63:32];
    exp[3] = 32'd0;
    exp[4] = 32'd0;
    exp[5] = wd;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; serial_in_ready = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL idle_req_ready got %b want 1", req_ready);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    for (int i = 0; i < (wr ? 6 : 5); i++) begin
      @(negedge clock);
      n_cmp++;
      if (serial_in_valid !== 1'b1 || serial_in_bits !== exp[i] || req_ready !== 1'b0 || serial_out_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL word%0d got v=%b bits=%h rr=%b sor=%b want v=1 bits=%h rr=0 sor=0",
                 i, serial_in_valid, serial_in_bits, req_ready, serial_out_ready, exp[i]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL drain got rv=%b rr=%b busy=%b want rv=0 rr=1 busy=0", resp_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, serial_in_valid, serial_out_ready, busy} !== 6'b0 || resp_rdata !== 32'd0 || serial_in_bits !== 32'd0) begin
      n_bad++; $display("FAIL reset_outputs got rr=%b rv=%b busy=%b siv=%b want all 0", req_ready, resp_valid, busy, serial_in_valid);
    end
    @(posedge clock); @(posedge clock); #1;
    n_cmp++;
    if (req_ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_held got rr=%b busy=%b want 0 0", req_ready, busy);
    end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++; $display("FAIL release_no_edge got rr=%b want 0", req_ready);
    end
    @(posedge clock); @(negedge clock);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL release_first_edge got rr=%b want 1", req_ready);
    end
  endtask

  task automatic test_read();
    issue(1'b0, 64'h0000_0000_8000_0000, 32'd0);
    serial_out_bits = 32'h1234_5678; serial_out_valid = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (serial_out_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL read_wait got sor=%b rv=%b want 1 0", serial_out_ready, resp_valid);
    end
    @(posedge clock); #1;
    serial_out_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h1234_5678 || resp_err !== 1'b0 || serial_out_ready !== 1'b0) begin
      n_bad++; $display("FAIL read_resp got rv=%b rdata=%h err=%b want 1 12345678 0", resp_valid, resp_rdata, resp_err);
    end
    drain();
  endtask

  task automatic test_write();
    issue(1'b1, 64'h0000_0001_8000_0010, 32'hDEAD_BEEF);
    @(negedge clock);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'd0 || resp_err !== 1'b0 || serial_in_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_bad++; $display("FAIL write_resp got rv=%b rdata=%h err=%b siv=%b rr=%b want 1 0 0 0 0",
                        resp_valid, resp_rdata, resp_err, serial_in_valid, req_ready);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [31:0] exp [5];
    int n, cyc;
    exp[0] = 32'd0; exp[1] = 32'h0000_0040; exp[2] = 32'h0000_0002; exp[3] = 32'd0; exp[4] = 32'd0;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h0000_0002_0000_0040; serial_in_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 20) begin
      serial_in_ready = (cyc % 2 == 0);
      @(negedge clock);
      n_cmp++;
      if (serial_in_valid !== 1'b1 || serial_in_bits !== exp[n]) begin
        n_bad++; $display("FAIL stall_word%0d cyc%0d got v=%b bits=%h want v=1 bits=%h", n, cyc, serial_in_valid, serial_in_bits, exp[n]);
      end
      if (serial_in_ready) n++;
      @(posedge clock); #1;
      cyc++;
    end
    n_cmp++;
    if (n != 5 || cyc != 9) begin
      n_bad++; $display("FAIL stall_count got words=%0d cycles=%0d want 5 9", n, cyc);
    end
    serial_out_bits = 32'hCAFE_F00D; serial_out_valid = 1'b1;
    @(posedge clock); #1;
    serial_out_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_F00D || resp_err !== 1'b0) begin
      n_bad++; $display("FAIL stall_resp got rv=%b rdata=%h err=%b want 1 cafef00d 0", resp_valid, resp_rdata, resp_err);
    end
    drain();
  endtask

  task automatic test_timeout();
    issue(1'b0, 64'h0000_0000_0000_0010, 32'd0);
    for (int r = 0; r < 8; r++) begin
      @(negedge clock);
      n_cmp++;
      if (resp_valid !== 1'b0 || serial_out_ready !== 1'b1) begin
        n_bad++; $display("FAIL timeout_wait%0d got rv=%b sor=%b want 0 1", r, resp_valid, serial_out_ready);
      end
      @(posedge clock); #1;
    end
    @(negedge clock);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0 || serial_out_ready !== 1'b0) begin
      n_bad++; $display("FAIL timeout_resp got rv=%b err=%b rdata=%h want 1 1 0", resp_valid, resp_err, resp_rdata);
    end
    drain();
  endtask

  task automatic test_expiry_race();
    issue(1'b0, 64'h0000_0000_0000_0020, 32'd0);
    for (int r = 0; r < 7; r++) begin
      @(posedge clock); #1;
    end
    serial_out_bits = 32'h0BAD_CAFE; serial_out_valid = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (serial_out_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL race_wait got sor=%b rv=%b want 1 0", serial_out_ready, resp_valid);
    end
    @(posedge clock); #1;
    serial_out_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BAD_CAFE || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        n_bad++; $display("FAIL race_hold%0d got rv=%b rdata=%h err=%b rr=%b want 1 0badcafe 0 0",
                          k, resp_valid, resp_rdata, resp_err, req_ready);
      end
      @(posedge clock); #1;
    end
    drain();
  endtask

  task automatic test_reset_mid();
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'hAAAA_BBBB_CCCC_DDDD; req_wdata = 32'h1111_2222; serial_in_ready = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    n_cmp++;
    if (serial_in_bits !== 32'hAAAA_BBBB) begin
      n_bad++; $display("FAIL mid_addr_hi got bits=%h want aaaabbbb", serial_in_bits);
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, serial_in_valid, serial_out_ready, busy} !== 6'b0 || serial_in_bits !== 32'd0 || resp_rdata !== 32'd0) begin
      n_bad++; $display("FAIL mid_reset got rr=%b rv=%b siv=%b bits=%h busy=%b want all 0",
                        req_ready, resp_valid, serial_in_valid, serial_in_bits, busy);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (req_ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_release got rr=%b busy=%b want 0 0", req_ready, busy);
    end
    issue(1'b1, 64'h0000_0000_0000_0005, 32'h55AA_55AA);
    @(negedge clock);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
      n_bad++; $display("FAIL mid_write_resp got rv=%b err=%b rdata=%h want 1 0 0", resp_valid, resp_err, resp_rdata);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_stall();
    test_timeout();
    test_expiry_race();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_tsi_master.md
# serial_tsi_master

Host-side sequencer for the 32-bit tethered serial link exposed by the simulation serial model. It accepts single-word read/write requests from a host-side requester and serialises each into the link's command word stream (cmd, address, length, data), then collects the read data word or times out. It sits between the host request port and the `serial_in`/`serial_out` stream pair of the serial model, owning the link exclusively.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024, cycles spent in read-wait before an error response; minimum 2
- TO_W, $clog2(TIMEOUT_CYCLES), width of the timeout counter (derived, not overridden)

Ports:
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset (reset==0 resets)
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1=write, 0=read
- req_addr  in  64  target byte address
- req_wdata  in  32  write data (ignored for reads)
- resp_valid  out  1  completion available
- resp_ready  in  1  requester consumes completion
- resp_rdata  out  32  read data; 0 for writes and errors
- resp_err  out  1  read timed out
- serial_in_valid  out  1  word offered to target
- serial_in_ready  in  1  target accepts word
- serial_in_bits  out  32  command/address/length/data word
- serial_out_valid  in  1  target offers word
- serial_out_ready  out  1  block accepts word
- serial_out_bits  in  32  word from target
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, RDWAIT, RESP.
- IDLE: req_ready=1 (once out of reset); on accept, latch write/addr/wdata, go CMD.
- CMD..LEN_HI: serial_in_valid=1; bits = 0 (read) or 1 (write), addr[31:0], addr[63:32], 0, 0 respectively (length field = words-1 = 0). Advance only on serial_in_valid && serial_in_ready; bits held stable while stalled.
- After LEN_HI: write → DATA (bits = latched wdata), then RESP with rdata=0, err=0. Read → RDWAIT.
- RDWAIT: serial_out_ready=1; timeout counter cleared on entry, increments each cycle. On serial_out_valid: latch bits, err=0, go RESP. If counter reaches TIMEOUT_CYCLES-1 with no valid: rdata=0, err=1, go RESP. Valid and expiry in the same cycle: data wins, err=0.
- RESP: resp_valid=1, rdata/err held stable; on resp_ready go IDLE.
- serial_out_ready=0 in every state except RDWAIT; words arriving elsewhere are left unaccepted.
- One transaction outstanding; no pipelining.

## Timing
- All outputs 0 while reset asserted, including req_ready; req_ready rises on the first clock edge after reset release (registered out-of-reset flag).
- Reset asserted mid-transaction: immediately to IDLE, all outputs 0, latched request discarded; no partial word retried.
- Accept at edge 0 with serial_in_ready held high: words on cycles 1–5 (cmd..LEN_HI); write data cycle 6, resp_valid cycle 7. Read: RDWAIT from cycle 6; serial_out_valid in cycle 6 → resp_valid cycle 7.
- req_ready low from the cycle after acceptance until the cycle after the response handshake.
- Timeout: with no target response, resp_valid with err=1 exactly TIMEOUT_CYCLES cycles after RDWAIT entry.
- serial_in_bits, resp_* driven from registered state and latched registers only (no combinational in→out paths except ready/valid gating by state).

## Structure
- Package serial_tsi_pkg: state enum, CMD_READ=32'd0, CMD_WRITE=32'd1, LEN_SINGLE=32'd0.
- One sub-module: serial_tsi_timeout (clear, enable, TO_W counter, expired flag at TIMEOUT_CYCLES-1).

## Test plan
- Write addr 0x0000_0001_8000_0010, data 0xDEADBEEF, ready high → serial_in words 1, 0x80000010, 0x00000001, 0, 0, 0xDEADBEEF on cycles 1–6; resp_valid cycle 7, rdata=0, err=0.
- Read addr 0x8000_0000, target returns 0x12345678 in the first RDWAIT cycle → words 0, 0x80000000, 0, 0, 0; resp_rdata=0x12345678, err=0 at cycle 7.
- Read, serial_in_ready toggled 1-0-1-0 → each word held stable while stalled, sequence unchanged, no duplicate or skipped word.
- Read with TIMEOUT_CYCLES=8, target silent → resp_valid, err=1, rdata=0 exactly 8 cycles after RDWAIT entry; next request accepted after resp_ready.
- serial_out_valid asserted on the expiry cycle → err=0, data returned; resp_ready held low 5 cycles → resp fields stable, req_ready low.
- reset pulled low during ADDR_HI → all outputs 0 at once; after release, req_ready=1 one edge later and a new write completes normally.
